// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: display reads take every pixel slot, and the
// free cycles go to the writer port or to a full-frame colour fill.
module vram_arbiter #(
  parameter int PIX_W = 12
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             p_tick,
  input  logic             video_on,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             wr_req,
  input  logic [14:0]      wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ack,
  output logic             wr_err,
  input  logic             clr_start,
  input  logic [PIX_W-1:0] clr_color,
  output logic             busy,
  output logic             mem_en,
  output logic             mem_we,
  output logic [14:0]      mem_addr,
  output logic [PIX_W-1:0] mem_wdata,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic [PIX_W-1:0] rgb
);

  // state | meaning
  // IDLE  | display reads plus writer grants
  // CLEAR | display reads plus one fill write per free cycle
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [14:0] FB_WORDS  = 15'd19200;
  localparam logic [14:0] FB_LAST   = 15'd19199;

  state_t           state, state_nx;
  logic [14:0]      fill_cnt, fill_cnt_nx;
  logic [PIX_W-1:0] clr_q;
  logic             rd_pend, rd_vid;
  logic             disp_slot;
  logic [14:0]      xs, ys, disp_addr;

  assign disp_slot = p_tick & video_on;
  assign xs        = 15'(x >> 2);
  assign ys        = 15'(y >> 2);
  // 160 = 128 + 32, so the row offset is built from two shifts
  assign disp_addr = (ys << 7) + (ys << 5) + xs;
  assign busy      = (state == CLEAR);

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fill_cnt <= '0;
      clr_q    <= '0;
      rd_pend  <= 1'b0;
      rd_vid   <= 1'b0;
      rgb      <= '0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_cnt_nx;
      if (state == IDLE && clr_start)
        clr_q <= clr_color;
      rd_pend  <= p_tick;
      rd_vid   <= video_on;
      if (rd_pend)
        rgb <= rd_vid ? mem_rdata : '0;
    end
  end

  always_comb begin
    state_nx    = state;
    fill_cnt_nx = fill_cnt;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    wr_ack      = 1'b0;
    wr_err      = 1'b0;
    // memory strobes stay quiet while reset is held, not just after the edge
    if (reset) begin
      if (disp_slot) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else begin
        case (state)
          IDLE: begin
            if (wr_req) begin
              wr_ack = 1'b1;
              if (wr_addr < FB_WORDS) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
              end else begin
                wr_err = 1'b1;
              end
            end
          end
          CLEAR: begin
            mem_en      = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = fill_cnt;
            mem_wdata   = clr_q;
            fill_cnt_nx = fill_cnt + 15'd1;
            if (fill_cnt == FB_LAST)
              state_nx = IDLE;
          end
          default: state_nx = IDLE;
        endcase
      end
      if (state == IDLE && clr_start) begin
        state_nx    = CLEAR;
        fill_cnt_nx = '0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port RAM.
module tb_vram_arbiter;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        p_tick, video_on;
  logic [9:0]  x, y;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack, wr_err;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        busy;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] rgb;

  logic [11:0] ram [0:19199];

  int n_assert = 0;
  int n_fail   = 0;
  int exp_addr;
  int ph;
  int wcount;
  bit done;

  vram_arbiter #(.PIX_W(12)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .clr_start(clr_start), .clr_color(clr_color),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb(rgb)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) begin
    if (mem_en) begin
      if (mem_we) begin
        if (mem_addr < 15'd19200) ram[mem_addr] <= mem_wdata;
      end else if (mem_addr < 15'd19200) begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) ram[i] = 12'h000;
    ram[162]  = 12'h0A5;
    mem_rdata = 12'h000;
    reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0; clr_color = '0;

    // reset state
    repeat (3) @(negedge clk_100MHz);
    wr_req = 1'b1; p_tick = 1'b1; video_on = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rgb", rgb, 0);
    @(negedge clk_100MHz);
    wr_req = 1'b0; p_tick = 1'b0; video_on = 1'b0;
    reset = 1'b1;

    // plain writer grant
    @(negedge clk_100MHz);
    wr_req = 1'b1; wr_addr = 15'h0050; wr_data = 12'hF00;
    #1;
    check("wr_ack", wr_ack, 1);
    check("wr_we", {mem_en, mem_we}, 2'b11);
    check("wr_addr", mem_addr, 15'h0050);
    check("wr_data", mem_wdata, 12'hF00);
    check("wr_err_low", wr_err, 0);
    @(negedge clk_100MHz);
    wr_req = 1'b0;
    #1;
    check("wr_ack_pulse", wr_ack, 0);

    // display read of word 162, rgb two edges later
    @(negedge clk_100MHz);
    p_tick = 1'b1; video_on = 1'b1; x = 10'd8; y = 10'd4;
    #1;
    check("disp_addr", mem_addr, 15'd162);
    check("disp_rd", {mem_en, mem_we}, 2'b10);
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    #1;
    check("rgb_hold", rgb, 12'h000);
    @(negedge clk_100MHz);
    #1;
    check("rgb_162", rgb, 12'h0A5);

    // readback of the word written earlier: column 320 -> word 80
    @(negedge clk_100MHz);
    p_tick = 1'b1; x = 10'd321; y = 10'd2;
    #1;
    check("disp_addr_80", mem_addr, 15'd80);
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    @(negedge clk_100MHz);
    #1;
    check("rgb_80", rgb, 12'hF00);

    // blank pixel strobe yields black and leaves the slot to the writer
    @(negedge clk_100MHz);
    p_tick = 1'b1; video_on = 1'b0; wr_req = 1'b1; wr_addr = 15'd90; wr_data = 12'h321;
    #1;
    check("blank_wr_ack", wr_ack, 1);
    @(negedge clk_100MHz);
    p_tick = 1'b0; wr_req = 1'b0;
    @(negedge clk_100MHz);
    #1;
    check("rgb_blank", rgb, 12'h000);

    // writer collides with display slot
    @(negedge clk_100MHz);
    video_on = 1'b1; x = 10'd8; y = 10'd4;
    p_tick = 1'b1; wr_req = 1'b1; wr_addr = 15'd100; wr_data = 12'h123;
    #1;
    check("coll_no_ack", wr_ack, 0);
    check("coll_rd", {mem_en, mem_we}, 2'b10);
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    #1;
    check("coll_ack_next", wr_ack, 1);
    check("coll_wr_addr", mem_addr, 15'd100);
    @(negedge clk_100MHz);
    wr_req = 1'b0;

    // out-of-range writer address
    @(negedge clk_100MHz);
    wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 12'hABC;
    #1;
    check("oor_ack", wr_ack, 1);
    check("oor_err", wr_err, 1);
    check("oor_no_we", mem_we, 0);
    @(negedge clk_100MHz);
    wr_addr = 15'd19199;
    #1;
    check("edge_err_low", wr_err, 0);
    check("edge_we", mem_we, 1);
    @(negedge clk_100MHz);
    wr_req = 1'b0;
    #1;
    check("oor_err_pulse", wr_err, 0);

    // full-frame fill with pixel strobes every fourth cycle
    @(negedge clk_100MHz);
    clr_start = 1'b1; clr_color = 12'h00F;
    #1;
    check("clr_start_busy", busy, 0);
    exp_addr = 0; ph = 0; done = 1'b0;
    for (int c = 0; c < 30000 && !done; c++) begin
      @(negedge clk_100MHz);
      wr_req = 1'b1; wr_addr = 15'd300; wr_data = 12'h777;
      p_tick = (ph == 0); ph = (ph + 1) % 4;
      clr_start = (exp_addr == 1000);
      clr_color = clr_start ? 12'h0F0 : 12'h00F;
      #1;
      if (!busy) begin
        done = 1'b1;
        check("ack_after_clear", wr_ack, !p_tick);
      end else begin
        check("clr_no_ack", wr_ack, 0);
        if (p_tick) begin
          check("clr_disp_rd", {mem_en, mem_we}, 2'b10);
        end else begin
          check("clr_we", {mem_en, mem_we}, 2'b11);
          check("clr_addr", mem_addr, exp_addr);
          check("clr_data", mem_wdata, 12'h00F);
          exp_addr++;
        end
      end
    end
    check("clr_done", done, 1);
    check("clr_count", exp_addr, 19200);
    @(negedge clk_100MHz);
    wr_req = 1'b0; p_tick = 1'b0; clr_start = 1'b0;
    #1;
    check("ram_first", ram[0], 12'h00F);
    check("ram_last", ram[19199], 12'h00F);
    check("ram_mid", ram[9600], 12'h00F);

    // reset in the middle of a second fill
    @(negedge clk_100MHz);
    clr_start = 1'b1; clr_color = 12'h0F0;
    @(negedge clk_100MHz);
    clr_start = 1'b0;
    done = 1'b0; ph = 0;
    for (int c = 0; c < 8000 && !done; c++) begin
      @(negedge clk_100MHz);
      p_tick = (ph == 0); ph = (ph + 1) % 4;
      #1;
      if (mem_we && mem_addr == 15'd5000) done = 1'b1;
    end
    check("fill_reached_5000", done, 1);
    check("rgb_before_rst", rgb, 12'h0F0);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rgb", rgb, 12'h000);
    check("midrst_mem_en", mem_en, 0);
    @(negedge clk_100MHz);
    reset = 1'b1;
    wcount = 0; ph = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_100MHz);
      p_tick = (ph == 0); ph = (ph + 1) % 4;
      #1;
      if (mem_we) wcount++;
    end
    check("postrst_no_writes", wcount, 0);
    check("postrst_busy", busy, 0);
    check("postrst_rgb", rgb, 12'h0F0);
    check("ram_untouched", ram[6000], 12'h00F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter PIX_W, default 12, SHALL set the width of a framebuffer word (4:4:4 RGB).
REQ-002 clk_100MHz  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 p_tick  input  1  SHALL be the pixel strobe from the VGA timing block, high 1 cycle in every 4.
REQ-005 video_on  input  1  SHALL mark the visible region from the VGA timing block.
REQ-006 x, y  input  10 each  SHALL be the current pixel column and row from the VGA timing block.
REQ-007 wr_req  input  1  SHALL be the writer request; wr_addr (15 bits) and wr_data (PIX_W bits) SHALL be held stable until wr_ack.
REQ-008 wr_ack  output  1  SHALL be a 1-cycle grant pulse for a writer request.
REQ-009 wr_err  output  1  SHALL be a 1-cycle pulse with wr_ack when wr_addr >= 19200.
REQ-010 clr_start  input  1  SHALL start a full-frame fill with clr_color (PIX_W bits).
REQ-011 busy  output  1  SHALL be high while a fill is in progress.
REQ-012 mem_en, mem_we  output  1 each  SHALL be the single-port framebuffer RAM enable and write enable.
REQ-013 mem_addr  output  15  SHALL be the RAM word address; mem_wdata output PIX_W  SHALL be the write data.
REQ-014 mem_rdata  input  PIX_W  SHALL be RAM read data, valid the cycle after a read is issued.
REQ-015 rgb  output  PIX_W  SHALL be the registered pixel colour to the display.

Function
REQ-016 The framebuffer SHALL be 160x120 words, each word covering a 4x4 screen-pixel block; address = (y>>2)*160 + (x>>2), computed as (y>>2)<<7 + (y>>2)<<5 + (x>>2) in 15 bits.
REQ-017 mem_en, mem_we, mem_addr, mem_wdata SHALL be combinational from current inputs and state; exactly one access (or none) SHALL occur per cycle.
REQ-018 Display slot: in any cycle with p_tick=1 and video_on=1, the block SHALL issue a read (mem_en=1, mem_we=0) at the REQ-016 address; this SHALL have absolute priority.
REQ-019 rgb SHALL update at the clock edge ending the cycle after a p_tick cycle: mem_rdata if video_on was 1 in that p_tick cycle, otherwise 0; total latency p_tick to rgb = 2 cycles; rgb SHALL hold between updates.
REQ-020 FSM states: IDLE, CLEAR.
REQ-021 IDLE: in any cycle not used by the display slot, if wr_req=1 the block SHALL assert wr_ack and, when wr_addr < 19200, write wr_data to wr_addr; when wr_addr >= 19200 it SHALL assert wr_err and not write.
REQ-022 IDLE -> CLEAR when clr_start=1; the writer MAY still be granted in that same cycle; the fill counter SHALL load 0.
REQ-023 CLEAR: each cycle not used by the display slot SHALL write clr_color (sampled at clr_start) to the counter address and increment the counter; wr_req SHALL receive no wr_ack.
REQ-024 CLEAR -> IDLE on the cycle the write to address 19199 is issued; busy SHALL drop in the following cycle.
REQ-025 clr_start while in CLEAR SHALL be ignored and SHALL NOT restart the counter.
REQ-026 busy SHALL be high exactly while the state is CLEAR.
REQ-027 Display slot and writer request in the same cycle: the display read wins and wr_ack SHALL stay 0 until the next free cycle.

Reset
REQ-028 While reset=0: state=IDLE, fill counter=0, rgb=0, wr_ack=0, wr_err=0, busy=0, mem_en=0, mem_we=0.
REQ-029 Reset asserted mid-fill SHALL abort it; after release the state SHALL be IDLE and no further fill writes SHALL occur.

Verification
REQ-030 wr_req=1, wr_addr=0x0050, wr_data=0xF00, no p_tick -> wr_ack 1 cycle, mem_we=1, mem_addr=0x0050, mem_wdata=0xF00.
REQ-031 p_tick=1, video_on=1, x=8, y=4 with RAM word 162=0x0A5 -> mem_addr=162 read that cycle, rgb=0x0A5 two cycles later.
REQ-032 wr_req held during a p_tick/video_on cycle -> no wr_ack that cycle, wr_ack in the next cycle.
REQ-033 wr_addr=19200 -> wr_ack and wr_err pulse together, mem_we=0.
REQ-034 clr_start with clr_color=0x00F, p_tick driven every 4 cycles, video_on=1 -> 19200 writes at addresses 0..19199, display reads never skipped, busy low after last write, wr_req unacked until then.
REQ-035 reset=0 asserted at fill address 5000 -> busy=0 and rgb=0 immediately; after release no writes without a new clr_start.
